processor_core_p: RTL

Parametrised successor to the 4-bit single-cycle processor. It executes one instruction at a time from an instruction stream with a valid/ready handshake, using a register file of NREGS × DATA_W bits. MUL, DIV and MOD run on an iterative multi-cycle unit. Results leave through a valid/ready output channel with a zero flag. It sits between the pin-level instruction loader and the result/output mux of the top-level wrapper.

---
 rtl/processor_pkg.sv | 41 ++++
 rtl/seq_muldiv.sv | 88 ++++++++
 rtl/processor_core_p.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared types for processor_core_p: instruction opcodes, ALU function codes
// and the control FSM states.
package processor_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_ALUI = 2'b01,
    OP_LOAD = 2'b10,
    OP_ALUR = 2'b11
  } opcode_e;

  typedef enum logic [3:0] {
    F_AND  = 4'd0,
    F_OR   = 4'd1,
    F_XOR  = 4'd2,
    F_NAND = 4'd3,
    F_NOR  = 4'd4,
    F_XNOR = 4'd5,
    F_ADD  = 4'd6,
    F_SUB  = 4'd7,
    F_MUL  = 4'd8,
    F_DIV  = 4'd9,
    F_MOD  = 4'd10,
    F_LT   = 4'd11,
    F_GT   = 4'd12,
    F_EQ   = 4'd13,
    F_SHL  = 4'd14,
    F_SHR  = 4'd15
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  function automatic logic is_muldiv(input func_e f);
    return (f == F_MUL) || (f == F_DIV) || (f == F_MOD);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider. One step per
// cycle, the first step taken on the start edge; done is high DATA_W cycles later.
module seq_muldiv #(
  parameter int DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product,
  output logic [DATA_W-1:0]     quotient,
  output logic [DATA_W-1:0]     remainder
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);

  logic                run;
  logic [CW-1:0]       cnt;
  logic [2*DATA_W-1:0] acc, mcand;
  logic [DATA_W-1:0]   mplier, rem, quo, dvsr;

  logic [2*DATA_W-1:0] s_acc, s_mcand, acc_n, mcand_n;
  logic [DATA_W-1:0]   s_mplier, s_rem, s_quo, s_dvsr;
  logic [DATA_W-1:0]   mplier_n, rem_n, quo_n;
  logic [DATA_W:0]     rem_sh;

  // The start edge seeds the datapath from the operands and applies step one.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    s_acc    = start ? '0 : acc;
    s_mcand  = start ? {{DATA_W{1'b0}}, a} : mcand;
    s_mplier = start ? b : mplier;
    s_rem    = start ? '0 : rem;
    s_quo    = start ? a : quo;
    s_dvsr   = start ? b : dvsr;

    acc_n    = s_mplier[0] ? (s_acc + s_mcand) : s_acc;
    mcand_n  = s_mcand << 1;
    mplier_n = s_mplier >> 1;

    rem_sh = {s_rem, s_quo[DATA_W-1]};
    if (rem_sh >= {1'b0, s_dvsr}) begin
      // The true difference is below the divisor, so DATA_W bits suffice.
      rem_n = rem_sh[DATA_W-1:0] - s_dvsr;
      quo_n = {s_quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[DATA_W-1:0];
      quo_n = {s_quo[DATA_W-2:0], 1'b0};
    end
  end

  assign done      = run && (cnt == CNT_LAST);
  assign product   = acc;
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
    end else if (start || (run && !done)) begin
      run    <= 1'b1;
      cnt    <= start ? CW'(1) : cnt + CW'(1);
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      rem    <= rem_n;
      quo    <= quo_n;
      dvsr   <= s_dvsr;
    end else if (done) begin
      run <= 1'b0;
      cnt <= '0;
    end
  end

endmodule

// File: rtl/processor_core_p.sv
// Parametrised single-issue processor core: register file, combinational ALU,
// iterative MUL/DIV/MOD, valid/ready instruction and result channels.
module processor_core_p
  import processor_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int NREGS  = 8,
  localparam int RA     = $clog2(NREGS),
  localparam int INST_W = 6 + 3 * RA + DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [INST_W-1:0]   inst,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*DATA_W-1:0] result,
  output logic                zero,
  output logic                busy
);

  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [2*DATA_W-1:0] wide_t;

  state_e          state, state_next;
  word_t           regs [NREGS];
  wide_t           result_q;
  logic            zero_q;
  logic [RA-1:0]   rd_q, rd_hi;
  func_e           func_q;

  opcode_e         opcode;
  func_e           func;
  logic [RA-1:0]   rs1, rs2, rd;
  word_t           imm, in1, in2, alu_w;
  wide_t           alu_res, single_res, md_res;
  logic            is_alu, go_multi, accept, md_start, single_we;
  word_t           single_wd;

  logic            md_done;
  wide_t           md_product;
  word_t           md_quotient, md_remainder;

  assign opcode = opcode_e'(inst[1:0]);
  assign func   = func_e'(inst[5:2]);
  assign rs2    = inst[6 +: RA];
  assign rs1    = inst[6 + RA +: RA];
  assign rd     = inst[6 + 2 * RA +: RA];
  assign imm    = inst[6 + 3 * RA +: DATA_W];

  assign in1 = regs[rs1];
  assign in2 = (opcode == OP_ALUR) ? regs[rs2] : imm;

  always_comb begin
    alu_w = '0;
    case (func)
      F_AND:  alu_w = in1 & in2;
      F_OR:   alu_w = in1 | in2;
      F_XOR:  alu_w = in1 ^ in2;
      F_NAND: alu_w = ~(in1 & in2);
      F_NOR:  alu_w = ~(in1 | in2);
      F_XNOR: alu_w = ~(in1 ^ in2);
      F_ADD:  alu_w = in1 + in2;
      F_SUB:  alu_w = in1 - in2;
      F_MOD:  alu_w = in1;
      F_LT:   alu_w = word_t'(in1 < in2);
      F_GT:   alu_w = word_t'(in1 > in2);
      F_EQ:   alu_w = word_t'(in1 == in2);
      F_SHL:  alu_w = (int'(in2) >= DATA_W) ? '0 : (in1 << in2);
      F_SHR:  alu_w = (int'(in2) >= DATA_W) ? '0 : (in1 >> in2);
      default: alu_w = '0;
    endcase
    // Only a divide by zero reaches here for F_DIV; it saturates the full width.
    alu_res = (func == F_DIV) ? '1 : {{DATA_W{1'b0}}, alu_w};
  end

  assign is_alu   = (opcode == OP_ALUI) || (opcode == OP_ALUR);
  assign go_multi = is_alu && is_muldiv(func) && ((func == F_MUL) || (in2 != '0));
  assign accept   = (state == S_IDLE) && inst_valid;
  assign md_start = accept && go_multi;

  always_comb begin
    single_res = '0;
    single_we  = 1'b0;
    single_wd  = '0;
    case (opcode)
      OP_READ: single_res = {{DATA_W{in1[DATA_W-1]}}, in1};
      OP_LOAD: begin
        single_res = {{DATA_W{1'b0}}, imm};
        single_we  = 1'b1;
        single_wd  = imm;
      end
      default: begin
        single_res = alu_res;
        single_we  = 1'b1;
        single_wd  = alu_res[DATA_W-1:0];
      end
    endcase
  end

  seq_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .a         (in1),
    .b         (in2),
    .done      (md_done),
    .product   (md_product),
    .quotient  (md_quotient),
    .remainder (md_remainder)
  );

  always_comb begin
    case (func_q)
      F_MUL:   md_res = md_product;
      F_DIV:   md_res = {{DATA_W{1'b0}}, md_quotient};
      default: md_res = {{DATA_W{1'b0}}, md_remainder};
    endcase
  end

  // RA-bit add wraps, so a MUL into the last register spills its high half to r0.
  assign rd_hi = rd_q + RA'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (inst_valid) state_next = go_multi ? S_EXEC : S_HOLD;
      S_EXEC: if (md_done)    state_next = S_HOLD;
      S_HOLD: if (res_ready)  state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is reset explicitly because its contents are
      // architecturally visible after reset; this keeps it in flops, not RAM.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      rd_q     <= '0;
      func_q   <= F_AND;
    end else begin
      if (md_start) begin
        rd_q   <= rd;
        func_q <= func;
      end else if (accept) begin
        if (single_we) regs[rd] <= single_wd;
        result_q <= single_res;
        zero_q   <= (single_res == '0);
      end
      if ((state == S_EXEC) && md_done) begin
        regs[rd_q] <= md_res[DATA_W-1:0];
        if (func_q == F_MUL) regs[rd_hi] <= md_res[2*DATA_W-1:DATA_W];
        result_q <= md_res;
        zero_q   <= (md_res == '0);
      end
    end
  end

  assign inst_ready = (state == S_IDLE);
  assign res_valid  = (state == S_HOLD);
  assign busy       = (state != S_IDLE);
  assign result     = result_q;
  assign zero       = zero_q;

endmodule
